decoder_3x8: RTL and testbench

Registered 3-to-8 line decoder with enable. Three select bits (in2 = MSB, in0 = LSB) form an index 0..7, and exactly one of eight one-hot outputs a..h is driven active. It is a general-purpose select/chip-enable generator. Outputs are registered on the single system clock so downstream logic sees glitch-free selects.

---
 rtl/decoder_3x8.sv | 83 ++++++++
 tb/tb_decoder_3x8.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_3x8.sv
// Registered 3-to-8 one-hot decoder with enable and a valid flag.
// Each output line is its own register lane fed from one full-case decode.

module decoder_3x8_lane #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic hot,
  output logic line
);

  always_ff @(posedge clk) begin
    if (rst) line <= ACTIVE_LOW;
    else     line <= hot ^ ACTIVE_LOW;
  end

endmodule

module decoder_3x8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic h,
  output logic valid
);

  localparam int NUM_LANES = 8;

  logic [2:0]           idx;
  logic [NUM_LANES-1:0] hot;
  logic [NUM_LANES-1:0] lines;

  assign idx = {in2, in1, in0};

  // Every select value maps to exactly one pattern, so an unknown select
  // can never light more than one line after synthesis.
  always_comb begin
    hot = '0;
    if (en) begin
      case (idx)
        3'd0: hot = 8'b0000_0001;
        3'd1: hot = 8'b0000_0010;
        3'd2: hot = 8'b0000_0100;
        3'd3: hot = 8'b0000_1000;
        3'd4: hot = 8'b0001_0000;
        3'd5: hot = 8'b0010_0000;
        3'd6: hot = 8'b0100_0000;
        3'd7: hot = 8'b1000_0000;
        default: hot = '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    decoder_3x8_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .hot  (hot[i]),
      .line (lines[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) valid <= 1'b0;
    else     valid <= en;
  end

  assign {h, g, f, e, d, c, b, a} = lines;

endmodule

// File: tb/tb_decoder_3x8.sv
// Scoreboard bench for decoder_3x8: active-high and active-low builds side by side.

module tb_decoder_3x8;

  typedef struct {
    logic [7:0] lines;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, in0, in1, in2;
  logic a_hi, b_hi, c_hi, d_hi, e_hi, f_hi, g_hi, h_hi, valid_hi;
  logic a_lo, b_lo, c_lo, d_lo, e_lo, f_lo, g_lo, h_lo, valid_lo;
  logic [7:0] hi_bus, lo_bus;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_3x8 #(.ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(en), .in0(in0), .in1(in1), .in2(in2),
    .a(a_hi), .b(b_hi), .c(c_hi), .d(d_hi), .e(e_hi), .f(f_hi), .g(g_hi), .h(h_hi),
    .valid(valid_hi)
  );

  decoder_3x8 #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .in0(in0), .in1(in1), .in2(in2),
    .a(a_lo), .b(b_lo), .c(c_lo), .d(d_lo), .e(e_lo), .f(f_lo), .g(g_lo), .h(h_lo),
    .valid(valid_lo)
  );

  assign hi_bus = {h_hi, g_hi, f_hi, e_hi, d_hi, c_hi, b_hi, a_hi};
  assign lo_bus = {h_lo, g_lo, f_lo, e_lo, d_lo, c_lo, b_lo, a_lo};

  // Drive one cycle of stimulus, record the expected registered result,
  // and return just after the edge that captures it.
  task automatic apply(input logic r, input logic e_in, input logic [2:0] idx);
    exp_t x;
    rst = r;
    en  = e_in;
    {in2, in1, in0} = idx;
    x.lines = (r || !e_in) ? 8'h00 : (8'h01 << idx);
    x.valid = !r && e_in;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      apply(i < 2, 1'b1, 3'd7);
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid) begin
        failures++;
        $display("FAIL reset_hi cyc=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, hi_bus, valid_hi, x.lines, x.valid);
      end
      checks++;
      if (lo_bus !== ~x.lines || valid_lo !== x.valid) begin
        failures++;
        $display("FAIL reset_lo cyc=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, lo_bus, valid_lo, ~x.lines, x.valid);
      end
    end
  endtask

  task automatic test_sequence();
    exp_t x;
    logic [2:0] pat [4];
    pat[0] = 3'b000; pat[1] = 3'b101; pat[2] = 3'b111; pat[3] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, pat[i]);
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid) begin
        failures++;
        $display("FAIL sequence idx=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 pat[i], hi_bus, valid_hi, x.lines, x.valid);
      end
    end
  endtask

  task automatic test_sweep();
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i));
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid || $countones(hi_bus) != 1) begin
        failures++;
        $display("FAIL sweep_hi idx=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, hi_bus, valid_hi, x.lines, x.valid);
      end
      checks++;
      if (lo_bus !== ~x.lines || valid_lo !== x.valid) begin
        failures++;
        $display("FAIL sweep_lo idx=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, lo_bus, valid_lo, ~x.lines, x.valid);
      end
    end
  endtask

  task automatic test_enable();
    exp_t x;
    logic [2:0] ens;
    ens = 3'b101;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, ens[2-i], 3'd3);
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid) begin
        failures++;
        $display("FAIL enable step=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, hi_bus, valid_hi, x.lines, x.valid);
      end
      checks++;
      if (lo_bus !== ~x.lines || valid_lo !== x.valid) begin
        failures++;
        $display("FAIL enable_lo step=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, lo_bus, valid_lo, ~x.lines, x.valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      apply(i == 6, 1'b1, 3'(i));
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid) begin
        failures++;
        $display("FAIL mid_reset idx=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, hi_bus, valid_hi, x.lines, x.valid);
      end
      checks++;
      if (lo_bus !== ~x.lines || valid_lo !== x.valid) begin
        failures++;
        $display("FAIL mid_reset_lo idx=%0d got lines=%b valid=%b want lines=%b valid=%b",
                 i, lo_bus, valid_lo, ~x.lines, x.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 24; i++) begin
      apply(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      x = sb.pop_front();
      checks++;
      if (hi_bus !== x.lines || valid_hi !== x.valid || lo_bus !== ~x.lines || valid_lo !== x.valid) begin
        failures++;
        $display("FAIL back_to_back n=%0d got hi=%b lo=%b v=%b%b want hi=%b v=%b",
                 i, hi_bus, lo_bus, valid_hi, valid_lo, x.lines, x.valid);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; {in2, in1, in0} = 3'b111;
    #1;
    test_reset();
    test_sequence();
    test_sweep();
    test_enable();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
